// File: rtl/decoder_pkg.sv
// Shared defaults, state encoding and width helpers for the turbo Decoder
// feeder block.
package decoder_pkg;

  localparam int DEC_FRAME_W    = 84;
  localparam int DEC_BEAT_W     = 21;
  localparam int DEC_BEATS      = 4;
  localparam int DEC_OUT_W      = 5;
  localparam int DEC_FIFO_DEPTH = 2;
  localparam int DEC_TIMEOUT    = 1024;

  // Index width that never collapses to zero bits for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_IDX_W = idx_w(DEC_BEATS);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESULT
  } feeder_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Small synchronous FIFO holding whole frames. Full is taken from the
// registered count, so a pop never frees a slot for a push in the same cycle.
module frame_fifo #(
  parameter int WIDTH = 84,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/decoder_feeder.sv
// Buffers received frames, streams each one to the Decoder as start/data
// beats, waits for done (or a timeout) and hands the result downstream.
module decoder_feeder
  import decoder_pkg::*;
#(
  parameter int FRAME_W    = DEC_FRAME_W,
  parameter int BEAT_W     = DEC_BEAT_W,
  parameter int BEATS      = DEC_BEATS,
  parameter int OUT_W      = DEC_OUT_W,
  parameter int FIFO_DEPTH = DEC_FIFO_DEPTH,
  parameter int TIMEOUT    = DEC_TIMEOUT
) (
  input  logic               clk_p_i,
  input  logic               reset_p_i,
  input  logic               frame_valid_i,
  input  logic [FRAME_W-1:0] frame_data_i,
  output logic               frame_ready_o,
  output logic               dec_start_o,
  output logic [BEAT_W-1:0]  dec_data_o,
  input  logic               dec_done_i,
  input  logic [OUT_W-1:0]   dec_result_i,
  output logic               res_valid_o,
  output logic [OUT_W-1:0]   res_data_o,
  output logic               res_timeout_o,
  input  logic               res_ready_i,
  output logic               busy_o,
  output logic [15:0]        frame_cnt_o
);

  localparam int BI_W  = (BEATS == DEC_BEATS) ? BEAT_IDX_W : idx_w(BEATS);
  localparam int TO_W  = idx_w(TIMEOUT);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a frame moves when frame_valid_i && frame_ready_o at a rising
  // edge; a result moves when res_valid_o && res_ready_i at a rising edge.
  // Neither valid may depend on its ready, and an offered result holds stable.

  feeder_state_t     state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [BI_W-1:0]    beat_q;
  logic [TO_W-1:0]    tcnt_q;
  logic               dec_start_q;
  logic [BEAT_W-1:0]  dec_data_q;
  logic               res_valid_q;
  logic [OUT_W-1:0]   res_data_q;
  logic               res_timeout_q;
  logic [15:0]        frame_cnt_q;

  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_pop_d;

  assign fifo_pop_d = (state_q == IDLE) && !fifo_empty;

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_p_i),
    .reset_i (reset_p_i),
    .push_i  (frame_valid_i),
    .wdata_i (frame_data_i),
    .pop_i   (fifo_pop_d),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      beat_q        <= '0;
      tcnt_q        <= '0;
      dec_start_q   <= 1'b0;
      dec_data_q    <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shreg_q <= fifo_rdata;
            beat_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          dec_start_q <= 1'b1;
          dec_data_q  <= shreg_q[BEAT_W-1:0];
          shreg_q     <= shreg_q >> BEAT_W;
          beat_q      <= beat_q + BI_W'(1);
          if (beat_q == BI_W'(BEATS - 1)) begin
            tcnt_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          dec_start_q <= 1'b0;
          dec_data_q  <= '0;
          tcnt_q      <= tcnt_q + TO_W'(1);
          // A done arriving on the last allowed cycle still beats the timeout.
          if (dec_done_i) begin
            res_data_q    <= dec_result_i;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= RESULT;
          end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_ready_o = !fifo_full;
  assign dec_start_o   = dec_start_q;
  assign dec_data_o    = dec_data_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_timeout_o = res_timeout_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign busy_o        = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_decoder_feeder.sv
// Directed and randomized bench for decoder_feeder with a small Decoder model
// and a queue-based scoreboard of expected beats and results.
module tb_decoder_feeder;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_p_i = 1'b0;
  logic        frame_valid_i = 1'b0;
  logic [83:0] frame_data_i = '0;
  logic        frame_ready_o;
  logic        dec_start_o;
  logic [20:0] dec_data_o;
  logic        dec_done_i = 1'b0;
  logic [4:0]  dec_result_i = '0;
  logic        res_valid_o;
  logic [4:0]  res_data_o;
  logic        res_timeout_o;
  logic        res_ready_i = 1'b0;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  decoder_feeder #(.TIMEOUT(TMO)) dut (
    .clk_p_i       (clk),
    .reset_p_i     (reset_p_i),
    .frame_valid_i (frame_valid_i),
    .frame_data_i  (frame_data_i),
    .frame_ready_o (frame_ready_o),
    .dec_start_o   (dec_start_o),
    .dec_data_o    (dec_data_o),
    .dec_done_i    (dec_done_i),
    .dec_result_i  (dec_result_i),
    .res_valid_o   (res_valid_o),
    .res_data_o    (res_data_o),
    .res_timeout_o (res_timeout_o),
    .res_ready_i   (res_ready_i),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int         delay;
    logic [4:0] result;
  } plan_t;

  logic [20:0] exp_beat_q[$];
  logic [5:0]  exp_q[$];
  plan_t       plan_q[$];

  int   checks = 0;
  int   errors = 0;
  int   frames_accepted = 0;
  int   last_beat_cyc = 0;
  bit   rand_ready = 1'b0;
  logic extra_done = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) res_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic push_frame(input logic [83:0] f, input int delay, input logic [4:0] r);
    int n;
    plan_t p;
    n = 0;
    frame_data_i  = f;
    frame_valid_i = 1'b1;
    while (!frame_ready_o && n < 400) begin
      step();
      n++;
    end
    check("push_ready", frame_ready_o, 1'b1);
    if (frame_ready_o) begin
      for (int k = 0; k < 4; k++) exp_beat_q.push_back(f[21*k +: 21]);
      p.delay  = delay;
      p.result = r;
      plan_q.push_back(p);
      // A done counts only if it lands within TIMEOUT cycles of waiting.
      if (delay >= 0 && delay <= TMO - 1) exp_q.push_back({1'b0, r});
      else exp_q.push_back(6'b100000);
      frames_accepted++;
    end
    step();
    frame_valid_i = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n;
    n = 0;
    while (!res_valid_o && n < budget) begin
      step();
      n++;
    end
    check("wait_res", res_valid_o, 1'b1);
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
  endtask

  function automatic logic [83:0] rand_frame();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[83:0];
  endfunction

  // ---------------- Decoder model and output monitor (negedge) ----------------
  int        beats_seen = 0;
  int        done_cd = -1;
  bit        prev_valid = 1'b0;
  logic [5:0] prev_res = '0;
  plan_t     cur_p;

  always @(negedge clk) begin
    if (reset_p_i) begin
      beats_seen = 0;
      done_cd    = -1;
      dec_done_i = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (dec_start_o) begin
        check("one_in_flight", res_valid_o, 1'b0);
        check("beat_queue", exp_beat_q.size() != 0, 1'b1);
        if (exp_beat_q.size() != 0) check("beat", dec_data_o, exp_beat_q.pop_front());
        beats_seen++;
        if (beats_seen == 4) begin
          beats_seen    = 0;
          last_beat_cyc = cyc;
          if (plan_q.size() != 0) begin
            cur_p        = plan_q.pop_front();
            done_cd      = cur_p.delay;
            dec_result_i = cur_p.result;
          end
        end
      end
      dec_done_i = extra_done;
      if (done_cd == 0) begin
        dec_done_i = 1'b1;
        done_cd    = -1;
      end else if (done_cd > 0) begin
        done_cd--;
      end
      if (prev_valid) begin
        check("res_hold_valid", res_valid_o, 1'b1);
        check("res_hold", {res_timeout_o, res_data_o}, prev_res);
      end
      if (res_valid_o) begin
        if (res_ready_i) begin
          check("res_queue", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("result", {res_timeout_o, res_data_o}, exp_q.pop_front());
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
          prev_res   = {res_timeout_o, res_data_o};
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  logic [83:0] f0;
  logic [83:0] fp;
  logic [4:0]  rr;

  initial begin
    // Reset
    reset_p_i = 1'b1;
    step();
    step();
    reset_p_i = 1'b0;
    check("rst_ready", frame_ready_o, 1'b1);
    check("rst_start", dec_start_o, 1'b0);
    check("rst_data", dec_data_o, 21'h0);
    check("rst_rvalid", res_valid_o, 1'b0);
    check("rst_rdata", res_data_o, 5'h0);
    check("rst_rtmo", res_timeout_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_cnt", frame_cnt_o, 16'd0);

    // Single frame with exact beat timing
    f0 = {21'h000A5, 21'h05432, 21'h1FFFFF, 21'h0ABCDE};
    push_frame(f0, 3, 5'h13);
    check("lat_n0", dec_start_o, 1'b0);
    step();
    check("lat_n1", dec_start_o, 1'b0);
    check("busy_n1", busy_o, 1'b1);
    step();
    check("b0_start", dec_start_o, 1'b1);
    check("b0_data", dec_data_o, 21'h0ABCDE);
    step();
    check("b1_data", dec_data_o, 21'h1FFFFF);
    step();
    check("b2_data", dec_data_o, 21'h05432);
    step();
    check("b3_start", dec_start_o, 1'b1);
    check("b3_data", dec_data_o, 21'h000A5);
    step();
    check("post_start", dec_start_o, 1'b0);
    check("post_data", dec_data_o, 21'h0);
    wait_res(100);
    check("single_data", res_data_o, 5'h13);
    check("single_tmo", res_timeout_o, 1'b0);
    handshake();
    check("single_rvalid", res_valid_o, 1'b0);
    check("single_cnt", frame_cnt_o, 16'd1);

    // Timeout: no done at all
    push_frame(rand_frame(), -1, 5'h1F);
    wait_res(100);
    check("tmo_latency", cyc - last_beat_cyc, TMO);
    check("tmo_flag", res_timeout_o, 1'b1);
    check("tmo_data", res_data_o, 5'h0);
    handshake();

    // Done on the last WAIT cycle wins over the timeout
    push_frame(rand_frame(), TMO - 1, 5'h07);
    wait_res(100);
    check("edge_latency", cyc - last_beat_cyc, TMO);
    check("edge_tmo", res_timeout_o, 1'b0);
    check("edge_data", res_data_o, 5'h07);
    handshake();

    // Done one cycle too late: timeout, and the late pulse lands in RESULT
    push_frame(rand_frame(), TMO, 5'h09);
    wait_res(100);
    check("late_tmo", res_timeout_o, 1'b1);
    check("late_data", res_data_o, 5'h0);
    step();
    step();
    step();
    check("late_hold", {res_timeout_o, res_data_o}, 6'b100000);
    handshake();
    check("cnt_after_4", frame_cnt_o, 16'(frames_accepted));

    // Backpressure: one in flight plus two buffered
    push_frame(rand_frame(), -1, 5'h00);
    push_frame(rand_frame(), int'($urandom_range(0, 10)), 5'($urandom_range(0, 31)));
    push_frame(rand_frame(), int'($urandom_range(0, 10)), 5'($urandom_range(0, 31)));
    check("bp_full", frame_ready_o, 1'b0);
    check("bp_busy", busy_o, 1'b1);
    frame_valid_i = 1'b1;
    frame_data_i  = rand_frame();
    for (int i = 0; i < 8; i++) begin
      check("bp_holdoff", frame_ready_o, 1'b0);
      step();
    end
    frame_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_res(200);
      handshake();
    end
    check("bp_cnt", frame_cnt_o, 16'(frames_accepted));

    // Result stall with a frame pending and a stray done pulse
    rr = 5'($urandom_range(0, 31));
    push_frame(rand_frame(), 2, rr);
    push_frame(rand_frame(), 1, 5'($urandom_range(0, 31)));
    wait_res(100);
    for (int i = 0; i < 10; i++) begin
      extra_done = (i == 3);
      check("stall_start", dec_start_o, 1'b0);
      check("stall_valid", res_valid_o, 1'b1);
      check("stall_res", {res_timeout_o, res_data_o}, {1'b0, rr});
      step();
    end
    extra_done = 1'b0;
    handshake();
    wait_res(100);
    handshake();
    check("stall_cnt", frame_cnt_o, 16'(frames_accepted));

    // Reset after beat 1 with another frame still buffered
    fp = rand_frame();
    push_frame(fp, 4, 5'h11);
    push_frame(rand_frame(), 4, 5'h12);
    for (int n = 0; n < 20 && !dec_start_o; n++) step();
    check("mid_beat0", dec_data_o, {21'h0, fp[20:0]});
    step();
    check("mid_beat1", dec_data_o, {21'h0, fp[41:21]});
    reset_p_i = 1'b1;
    exp_beat_q.delete();
    plan_q.delete();
    exp_q.delete();
    frames_accepted = 0;
    step();
    check("mid_start", dec_start_o, 1'b0);
    check("mid_ready", frame_ready_o, 1'b1);
    check("mid_busy", busy_o, 1'b0);
    check("mid_cnt", frame_cnt_o, 16'd0);
    check("mid_rvalid", res_valid_o, 1'b0);
    reset_p_i = 1'b0;
    push_frame(rand_frame(), 4, 5'h15);
    wait_res(100);
    check("after_rst_data", {res_timeout_o, res_data_o}, {1'b0, 5'h15});
    handshake();
    check("after_rst_cnt", frame_cnt_o, 16'd1);

    // Random traffic with random downstream readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) step();
      push_frame(rand_frame(), int'($urandom_range(0, 19)), 5'($urandom_range(0, 31)));
    end
    for (int n = 0; n < 3000 && exp_q.size() != 0; n++) step();
    rand_ready  = 1'b0;
    res_ready_i = 1'b0;
    check("drain_empty", exp_q.size(), 0);
    check("drain_beats", exp_beat_q.size(), 0);
    check("drain_busy", busy_o, 1'b0);
    check("drain_cnt", frame_cnt_o, 16'(frames_accepted));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
